// File: rtl/bk_arith_pkg.sv
// Shared constants, FSM encoding and prefix-combine helper for the Brent-Kung arithmetic blocks.
package bk_arith_pkg;

  localparam int unsigned SLICE_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Associative prefix operator: hi covers the more significant span.
  function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_add16.sv
// Combinational 16-bit Brent-Kung prefix adder: up-sweep to 2/4/8/16-bit groups, then back-fill.
module bk_add16
  import bk_arith_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] p0;
  gp_t  [15:0] l0, l1, l2, l3, l4, l5, l6, l7;
  logic [16:0] c;

  assign p0 = x ^ y;

  // cin is folded into bit 0 so every prefix term already spans from the carry-in.
  for (genvar i = 0; i < 16; i++) begin : g_init
    if (i == 0) begin : g_b0
      assign l0[i].g = (x[i] & y[i]) | (p0[i] & cin);
    end else begin : g_bn
      assign l0[i].g = x[i] & y[i];
    end
    assign l0[i].p = p0[i];
  end

  for (genvar i = 0; i < 16; i++) begin : g_up1
    if ((i % 2) == 1) begin : g_m
      assign l1[i] = gp_merge(l0[i], l0[i-1]);
    end else begin : g_t
      assign l1[i] = l0[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_up2
    if ((i % 4) == 3) begin : g_m
      assign l2[i] = gp_merge(l1[i], l1[i-2]);
    end else begin : g_t
      assign l2[i] = l1[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_up3
    if ((i % 8) == 7) begin : g_m
      assign l3[i] = gp_merge(l2[i], l2[i-4]);
    end else begin : g_t
      assign l3[i] = l2[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_up4
    if (i == 15) begin : g_m
      assign l4[i] = gp_merge(l3[i], l3[i-8]);
    end else begin : g_t
      assign l4[i] = l3[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_dn1
    if (i == 11) begin : g_m
      assign l5[i] = gp_merge(l4[i], l4[i-4]);
    end else begin : g_t
      assign l5[i] = l4[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_dn2
    if (((i % 4) == 1) && (i >= 4)) begin : g_m
      assign l6[i] = gp_merge(l5[i], l5[i-2]);
    end else begin : g_t
      assign l6[i] = l5[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_dn3
    if (((i % 2) == 0) && (i >= 2)) begin : g_m
      assign l7[i] = gp_merge(l6[i], l6[i-1]);
    end else begin : g_t
      assign l7[i] = l6[i];
    end
  end

  assign c[0] = cin;
  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign c[i+1] = l7[i].g;
    assign s[i]   = p0[i] ^ c[i];
  end

  assign cout = c[16];

endmodule

// File: rtl/bk_serial_subtractor.sv
// Multi-cycle wide subtractor: one 16-bit slice per clock through a shared Brent-Kung core.
module bk_serial_subtractor
  import bk_arith_pkg::*;
#(
  parameter int unsigned WORDS = 4
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] diff,
  output logic                     bout,
  output logic                     ovf,
  output logic                     zero
);

  localparam int unsigned W        = SLICE_W * WORDS;
  localparam int unsigned CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [W-1:0]       a_q, b_q, diff_q;
  logic               bout_q, ovf_q, zero_q, out_valid_q;

  logic [SLICE_W-1:0] a_s, b_s, s;
  logic               cout;
  logic [W-1:0]       diff_next;

  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_s = a_q[i*SLICE_W +: SLICE_W];
        b_s = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // Subtraction as a + ~b + carry, with the carry register holding the inverted borrow.
  bk_add16 u_add (
    .x    (a_s),
    .y    (~b_s),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_comb begin
    diff_next = diff_q;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (cnt == CNT_W'(i)) begin
        diff_next[i*SLICE_W +: SLICE_W] = s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~bin;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          diff_q <= diff_next;
          carry  <= cout;
          if (cnt == LAST_CNT) begin
            cnt         <= '0;
            bout_q      <= ~cout;
            ovf_q       <= (a_q[W-1] != b_q[W-1]) && (diff_next[W-1] != a_q[W-1]);
            zero_q      <= (diff_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bk_serial_subtractor.sv
// Self-checking bench for bk_serial_subtractor: directed vectors, handshake/reset cases, random regression.
module tb_bk_serial_subtractor;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 64;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, bin;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, bout, ovf, zero;
  logic [W-1:0] diff;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [W-1:0] exp_diff;
  logic         exp_bout, exp_ovf, exp_zero;
  bit           model_ok = 1'b0;

  bk_serial_subtractor #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Reference: plain wide arithmetic with one extra bit for the borrow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] t;
    t        = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    exp_diff = t[W-1:0];
    exp_bout = t[W];
    exp_ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    exp_zero = (t[W-1:0] == '0);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && model_ok) begin
      chk("diff",     diff,                 exp_diff);
      chk("bout",     {63'd0, bout},        {63'd0, exp_bout});
      chk("ovf",      {63'd0, ovf},         {63'd0, exp_ovf});
      chk("zero",     {63'd0, zero},        {63'd0, exp_zero});
      chk("ready_lo", {63'd0, in_ready},    64'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input int unsigned hold);
    int unsigned n;
    logic [W-1:0] snap;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    a = ta; b = tb; bin = tbin;
    model(ta, tb, tbin);
    model_ok  = 1'b1;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(WORDS));
    if (hold > 0) begin
      snap = diff;
      for (int unsigned h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        a = 64'd1; b = 64'd0;
        @(posedge clk);
        #1;
        chk("hold_diff",  diff,               snap);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_ready", {63'd0, in_ready},  64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_ready", {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff",      diff,               64'd0);
    chk("rst_flags",     {61'd0, bout, ovf, zero}, 64'd0);
    rst = 1'b0;

    run_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, 0);
    chk("d1_diff",  diff, 64'h0000_0000_0000_FFFF);
    chk("d1_flags", {61'd0, bout, ovf, zero}, 64'd0);

    run_op(64'h0, 64'h1, 1'b0, 0);
    chk("d2_diff",  diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("d2_flags", {61'd0, bout, ovf, zero}, 64'd4);

    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0);
    chk("d3_diff",  diff, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("d3_flags", {61'd0, bout, ovf, zero}, 64'd2);

    run_op(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    chk("d4_diff",  diff, 64'd0);
    chk("d4_flags", {61'd0, bout, ovf, zero}, 64'd1);

    run_op(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 5);
    chk("d5_diff",  diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("d5_flags", {61'd0, bout, ovf, zero}, 64'd4);

    // Abort during CALC with two slices done.
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; bin = 1'b0;
    model_ok = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_ready", {63'd0, in_ready},  64'd1);
    chk("abort_diff",  diff,               64'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wins", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;

    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0);
    chk("d6_diff", diff, 64'h0246_8ACF_1357_9BCF);

    for (int unsigned k = 0; k < 10000; k++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (k % 16 == 0) ? ra : {$urandom, $urandom};
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
